// File: rtl/dut_chain.sv
// dut_chain: STAGES chained registered compute stages feeding a
// first-word-fall-through output FIFO.
//
// Ports:
//   clk, reset_l                        clock, async active-low reset
//   in_valid/in_ready                   operand handshake
//   in_data, in_key, in_mode            operand, key, op select
//   out_valid/out_ready                 FIFO head handshake
//   out_data                            FIFO head (0 when empty)
//   out_count                           pops so far, saturating
//   out_carry                           sticky add-overflow of the head item
//                                       (only when DUT_CHAIN_CARRY_EN is defined)
//
// Optional feature macro: DUT_CHAIN_CARRY_EN
//
// Stage op (i = stage index, all mod 2^WIDTH):
//   0: d + key   1: d ^ rol(key, i % WIDTH)   2: d + key + i   3: d

module dut_chain_stage #(
   parameter int WIDTH = 8,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic             adv,
   input  logic             vld_in,
   input  logic [WIDTH-1:0] d_in,
   input  logic [WIDTH-1:0] key_in,
   input  logic [1:0]       mode_in,
`ifdef DUT_CHAIN_CARRY_EN
   input  logic             carry_in,
   output logic             carry_q,
`endif
   output logic             vld_q,
   output logic [WIDTH-1:0] d_q,
   output logic [WIDTH-1:0] key_q,
   output logic [1:0]       mode_q
);
   localparam int               ROT   = IDX % WIDTH;
   localparam logic [WIDTH-1:0] IDX_W = WIDTH'(IDX);

   logic [2*WIDTH-1:0] kk;
   logic [WIDTH-1:0]   rol_key;
   logic [WIDTH+1:0]   sum0, sum2;
   logic [WIDTH-1:0]   f;
   logic               ovf;

   // rotate-left = upper half of the doubled key shifted left
   assign kk      = {key_in, key_in} << ROT;
   assign rol_key = kk[2*WIDTH-1:WIDTH];
   assign sum0    = {2'b00, d_in} + {2'b00, key_in};
   assign sum2    = sum0 + {2'b00, IDX_W};

   always_comb begin
      f   = d_in;
      ovf = 1'b0;
      unique case (mode_in)
         2'd0: begin f = sum0[WIDTH-1:0]; ovf = |sum0[WIDTH+1:WIDTH]; end
         2'd1: f = d_in ^ rol_key;
         2'd2: begin f = sum2[WIDTH-1:0]; ovf = |sum2[WIDTH+1:WIDTH]; end
         default: f = d_in;
      endcase
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         vld_q  <= 1'b0;
         d_q    <= '0;
         key_q  <= '0;
         mode_q <= '0;
`ifdef DUT_CHAIN_CARRY_EN
         carry_q <= 1'b0;
`endif
      end else if (adv) begin
         vld_q  <= vld_in;
         d_q    <= f;
         key_q  <= key_in;
         mode_q <= mode_in;
`ifdef DUT_CHAIN_CARRY_EN
         carry_q <= carry_in | ovf;
`endif
      end
   end

`ifndef DUT_CHAIN_CARRY_EN
   logic unused_ovf;
   assign unused_ovf = ovf;
`endif
endmodule

module dut_chain #(
   parameter int WIDTH      = 8,
   parameter int STAGES     = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [WIDTH-1:0] in_key,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
`ifdef DUT_CHAIN_CARRY_EN
   output logic             out_carry,
`endif
   output logic [CNT_W-1:0] out_count
);
   localparam int AW = $clog2(FIFO_DEPTH);

   // index 0 is the input side; index i+1 is the output of stage i
   logic [STAGES:0]            vld_pipe;
   logic [STAGES:0][WIDTH-1:0] d_pipe;
   logic [STAGES:0][WIDTH-1:0] key_pipe;
   logic [STAGES:0][1:0]       mode_pipe;
`ifdef DUT_CHAIN_CARRY_EN
   logic [STAGES:0]            carry_pipe;
   assign carry_pipe[0] = 1'b0;
`endif

   logic adv, push, pop, fifo_full;

   assign vld_pipe[0]  = in_valid;
   assign d_pipe[0]    = in_data;
   assign key_pipe[0]  = in_key;
   assign mode_pipe[0] = in_mode;

   // full comes from the registered count, so a pop while full cannot
   // free a slot for a push in the same cycle
   assign adv      = !vld_pipe[STAGES] || !fifo_full;
   assign in_ready = adv;
   assign push     = adv && vld_pipe[STAGES];
   assign pop      = out_valid && out_ready;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      dut_chain_stage #(.WIDTH(WIDTH), .IDX(i)) u_stage (
         .clk     (clk),
         .reset_l (reset_l),
         .adv     (adv),
         .vld_in  (vld_pipe[i]),
         .d_in    (d_pipe[i]),
         .key_in  (key_pipe[i]),
         .mode_in (mode_pipe[i]),
`ifdef DUT_CHAIN_CARRY_EN
         .carry_in(carry_pipe[i]),
         .carry_q (carry_pipe[i+1]),
`endif
         .vld_q   (vld_pipe[i+1]),
         .d_q     (d_pipe[i+1]),
         .key_q   (key_pipe[i+1]),
         .mode_q  (mode_pipe[i+1])
      );
   end

   // key/mode of the last stage are not needed past the chain
   logic unused_tail;
   assign unused_tail = ^{key_pipe[STAGES], mode_pipe[STAGES]};

   // ---- output FIFO ----
   logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
`ifdef DUT_CHAIN_CARRY_EN
   logic             mem_c [FIFO_DEPTH];
`endif
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      occ;

   assign fifo_full = (occ == (AW+1)'(FIFO_DEPTH));
   assign out_valid = (occ != '0);
   assign out_data  = out_valid ? mem_d[rd_ptr] : '0;
`ifdef DUT_CHAIN_CARRY_EN
   assign out_carry = out_valid ? mem_c[rd_ptr] : 1'b0;
`endif

   // storage needs no reset: the head is gated by out_valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem_d[wr_ptr] <= d_pipe[STAGES];
`ifdef DUT_CHAIN_CARRY_EN
         mem_c[wr_ptr] <= carry_pipe[STAGES];
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         out_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      occ <= occ + 1'b1;
         else if (pop && !push) occ <= occ - 1'b1;
         if (pop && out_count != '1) out_count <= out_count + 1'b1;
      end
   end
endmodule
